// File: rtl/pattern_bist_driver.sv
// -----------------------------------------------------------------------------
// pattern_bist_driver
//   On-chip BIST harness placed beside a generated pattern block. A 16-bit
//   Fibonacci LFSR supplies one IN_W-bit stimulus vector per cycle for
//   NUM_VECTORS cycles. The pattern block's OUT_W-bit response is folded into
//   a 16-bit MISR, SETTLE cycles after the matching vector was driven.
//
// Ports
//   blif_clk_net    in   1      clock, rising edge
//   blif_reset_net  in   1      asynchronous reset, active-low
//   start           in   1      run request, only honoured in IDLE
//   stim_o          out  IN_W   stimulus vector (low IN_W bits of the LFSR)
//   resp_i          in   OUT_W  pattern block response
//   busy            out  1      high in LOAD / DRIVE / DRAIN
//   done            out  1      one-cycle pulse once the signature is final
//   sig_valid       out  1      signature stable; cleared by the next run
//   signature       out  16     MISR contents
//   vec_count       out  16     vectors driven in this run (saturating)
// -----------------------------------------------------------------------------
module pattern_bist_driver #(
   parameter int unsigned IN_W        = 11,
   parameter int unsigned OUT_W       = 8,
   parameter int unsigned NUM_VECTORS = 256,
   parameter int unsigned SETTLE      = 3,
   parameter logic [15:0] SEED        = 16'hACE1
) (
   input  logic             blif_clk_net,
   input  logic             blif_reset_net,
   input  logic             start,
   output logic [IN_W-1:0]  stim_o,
   input  logic [OUT_W-1:0] resp_i,
   output logic             busy,
   output logic             done,
   output logic             sig_valid,
   output logic [15:0]      signature,
   output logic [15:0]      vec_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRIVE,
      S_DRAIN,
      S_DONE
   } state_e;

   // An all-zero seed would lock the LFSR, so it is replaced by 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

   // One phase counter serves both DRIVE (vector index) and DRAIN (settle
   // countdown). It is separate from vec_count because vec_count saturates
   // while the run length itself must stay exact.
   localparam int unsigned PHASE_MAX = (NUM_VECTORS > SETTLE) ? NUM_VECTORS : SETTLE;
   localparam int unsigned CNT_W     = $clog2(PHASE_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_VEC    = CNT_W'(NUM_VECTORS - 1);
   localparam logic [CNT_W-1:0] LAST_SETTLE = CNT_W'(SETTLE - 1);

   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

   function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] r);
      return lfsr_step(s) ^ r;
   endfunction

   state_e            state_q, state_d;
   logic [15:0]       lfsr_q, lfsr_d;
   logic [15:0]       misr_q, misr_d;
   logic [IN_W-1:0]   stim_q, stim_d;
   logic [15:0]       vec_cnt_q, vec_cnt_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              sig_valid_q, sig_valid_d;
   logic [SETTLE-1:0] cap_vld_q, cap_vld_d;

   always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
      if (!blif_reset_net) begin
         state_q     <= S_IDLE;
         lfsr_q      <= '0;
         misr_q      <= '0;
         stim_q      <= '0;
         vec_cnt_q   <= '0;
         cnt_q       <= '0;
         sig_valid_q <= 1'b0;
         cap_vld_q   <= '0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         misr_q      <= misr_d;
         stim_q      <= stim_d;
         vec_cnt_q   <= vec_cnt_d;
         cnt_q       <= cnt_d;
         sig_valid_q <= sig_valid_d;
         cap_vld_q   <= cap_vld_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      misr_d      = misr_q;
      stim_d      = stim_q;
      vec_cnt_d   = vec_cnt_q;
      cnt_d       = cnt_q;
      sig_valid_d = sig_valid_q;
      busy        = 1'b0;
      done        = 1'b0;

      // Each DRIVE cycle launches a tag; when it leaves the last stage the
      // response to that vector has settled and is folded into the MISR.
      cap_vld_d = (cap_vld_q << 1) | SETTLE'(state_q == S_DRIVE);
      if (cap_vld_q[SETTLE-1]) begin
         misr_d = misr_step(misr_q, 16'(resp_i));
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_LOAD;
               sig_valid_d = 1'b0;
            end
         end
         S_LOAD: begin
            busy      = 1'b1;
            lfsr_d    = SEED_EFF;
            misr_d    = '0;
            vec_cnt_d = '0;
            cnt_d     = '0;
            // stim_o is registered alongside the LFSR so the vector on the
            // pins always equals the LFSR state during DRIVE.
            stim_d    = SEED_EFF[IN_W-1:0];
            state_d   = S_DRIVE;
         end
         S_DRIVE: begin
            busy   = 1'b1;
            lfsr_d = lfsr_step(lfsr_q);
            if (vec_cnt_q != 16'hFFFF) begin
               vec_cnt_d = vec_cnt_q + 16'd1;
            end
            if (cnt_q == LAST_VEC) begin
               // Last vector stays on the pins through DRAIN.
               cnt_d   = '0;
               state_d = S_DRAIN;
            end else begin
               cnt_d  = cnt_q + CNT_W'(1);
               stim_d = lfsr_d[IN_W-1:0];
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (cnt_q == LAST_SETTLE) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            done        = 1'b1;
            sig_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign stim_o    = stim_q;
   assign signature = misr_q;
   assign vec_count = vec_cnt_q;
   assign sig_valid = sig_valid_q;

endmodule

// File: tb/tb_pattern_bist_driver.sv
// -----------------------------------------------------------------------------
// tb_pattern_bist_driver
//   Three instances: A (SEED=1, 4 vectors, settle 3), B (SEED=0, 1 vector,
//   settle 1, constant 0xFF response) and C (default parameters). A and C
//   drive their pattern-block stand-in: a SETTLE-deep delay line on stim_o
//   followed by a fixed 8-bit mixing function.
// -----------------------------------------------------------------------------
module tb_pattern_bist_driver;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] stim_q[$];
   logic [31:0] sig_q[$];

   // ---------------- instance A ----------------
   logic        a_start, a_busy, a_done, a_sv, a_hash;
   logic [10:0] a_stim;
   logic [7:0]  a_resp, a_const;
   logic [15:0] a_sig, a_vc;
   logic [10:0] a_dl [3];

   // ---------------- instance B ----------------
   logic        b_start, b_busy, b_done, b_sv;
   logic [10:0] b_stim;
   logic [7:0]  b_resp;
   logic [15:0] b_sig, b_vc;

   // ---------------- instance C ----------------
   logic        c_start, c_busy, c_done, c_sv;
   logic [10:0] c_stim;
   logic [7:0]  c_resp;
   logic [15:0] c_sig, c_vc;
   logic [10:0] c_dl [3];

   function automatic logic [7:0] mixf(input logic [10:0] x);
      return x[7:0] ^ {x[10:8], x[4:0]} ^ 8'h5A;
   endfunction

   // Reference signature: vector k = low 11 bits of the k-th LFSR state,
   // response = mixf(vector) or a constant, folded with the MISR recurrence.
   function automatic logic [15:0] gold(input logic [15:0] seed, input int n,
                                        input bit hm, input logic [7:0] c);
      logic [15:0] s, m;
      logic [7:0]  r;
      s = (seed == 16'h0000) ? 16'h0001 : seed;
      m = 16'h0000;
      for (int k = 0; k < n; k++) begin
         r = hm ? mixf(s[10:0]) : c;
         m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]} ^ {8'h00, r};
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
      return m;
   endfunction

   always @(posedge clk) begin
      a_dl[0] <= a_stim;
      a_dl[1] <= a_dl[0];
      a_dl[2] <= a_dl[1];
      c_dl[0] <= c_stim;
      c_dl[1] <= c_dl[0];
      c_dl[2] <= c_dl[1];
   end

   assign a_resp = a_hash ? mixf(a_dl[2]) : a_const;
   assign c_resp = mixf(c_dl[2]);
   assign b_resp = 8'hFF;

   pattern_bist_driver #(.IN_W(11), .OUT_W(8), .NUM_VECTORS(4), .SETTLE(3), .SEED(16'h0001)) dut_a (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .start(a_start), .stim_o(a_stim),
      .resp_i(a_resp), .busy(a_busy), .done(a_done), .sig_valid(a_sv),
      .signature(a_sig), .vec_count(a_vc));

   pattern_bist_driver #(.IN_W(11), .OUT_W(8), .NUM_VECTORS(1), .SETTLE(1), .SEED(16'h0000)) dut_b (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .start(b_start), .stim_o(b_stim),
      .resp_i(b_resp), .busy(b_busy), .done(b_done), .sig_valid(b_sv),
      .signature(b_sig), .vec_count(b_vc));

   pattern_bist_driver dut_c (
      .blif_clk_net(clk), .blif_reset_net(rst_n), .start(c_start), .stim_o(c_stim),
      .resp_i(c_resp), .busy(c_busy), .done(c_done), .sig_valid(c_sv),
      .signature(c_sig), .vec_count(c_vc));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One run on A. Sample i is the negedge in cycle T+i, T being the start edge.
   task automatic run_a(input bit hm, input logic [7:0] cval, input bit extra_starts);
      logic [15:0] s;
      int dones, busys;
      s = 16'h0001;
      for (int k = 0; k < 4; k++) begin
         stim_q.push_back(32'(s[10:0]));
         s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
      end
      sig_q.push_back(32'(gold(16'h0001, 4, hm, cval)));
      a_hash  = hm;
      a_const = cval;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      check("a_busy_load", a_busy, 1);
      check("a_sigvalid_clr", a_sv, 0);
      dones = 0;
      busys = 1;
      for (int i = 2; i <= 11; i++) begin
         @(negedge clk);
         a_start = extra_starts && (i == 3 || i == 6);
         if (a_done) dones++;
         if (a_busy) busys++;
         if (i <= 5) check("a_stim", a_stim, stim_q.pop_front());
         if (i == 9) begin
            check("a_done_lat", a_done, 1);
            check("a_sig", a_sig, sig_q.pop_front());
         end
      end
      check("a_done_count", dones, 1);
      check("a_busy_len", busys, 8);
      check("a_sig_valid", a_sv, 1);
      check("a_vec_count", a_vc, 4);
   endtask

   initial begin
      rst_n   = 1'b1;
      a_start = 1'b0;
      b_start = 1'b0;
      c_start = 1'b0;
      a_hash  = 1'b0;
      a_const = 8'h00;
      #3 rst_n = 1'b0;
      repeat (2) @(negedge clk);

      // reset values
      check("rst_stim", a_stim, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_sig_valid", a_sv, 0);
      check("rst_signature", a_sig, 0);
      check("rst_vec_count", a_vc, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // zero response, then mixed response, then with start pulses mid-run
      run_a(1'b0, 8'h00, 1'b0);
      run_a(1'b1, 8'h00, 1'b0);
      run_a(1'b1, 8'h00, 1'b1);
      run_a(1'b0, 8'hC3, 1'b0);

      // B: single vector, zero seed, start held high across DONE
      stim_q.push_back(32'h001);
      sig_q.push_back(32'(gold(16'h0000, 1, 1'b0, 8'hFF)));
      sig_q.push_back(32'(gold(16'h0000, 1, 1'b0, 8'hFF)));
      @(negedge clk) b_start = 1'b1;
      @(negedge clk);
      check("b_busy_load", b_busy, 1);
      @(negedge clk);
      check("b_stim_seed0", b_stim, stim_q.pop_front());
      @(negedge clk);
      @(negedge clk);
      check("b_done_lat", b_done, 1);
      check("b_sig", b_sig, sig_q.pop_front());
      @(negedge clk);
      check("b_idle_busy", b_busy, 0);
      check("b_sig_valid", b_sv, 1);
      @(negedge clk);
      check("b_rerun_busy", b_busy, 1);
      check("b_rerun_sv_clr", b_sv, 0);
      b_start = 1'b0;
      repeat (3) @(negedge clk);
      check("b_rerun_done", b_done, 1);
      check("b_rerun_sig", b_sig, sig_q.pop_front());
      check("b_vec_count", b_vc, 1);

      // C: default parameters, bounded wait for done
      sig_q.push_back(32'(gold(16'hACE1, 256, 1'b1, 8'h00)));
      @(negedge clk) c_start = 1'b1;
      @(negedge clk) c_start = 1'b0;
      begin
         int lat;
         lat = 0;
         for (int i = 2; i <= 400; i++) begin
            @(negedge clk);
            if (i == 2) check("c_first_stim", c_stim, 32'h4E1);
            if (c_done) begin
               lat = i;
               break;
            end
         end
         check("c_done_lat", lat, 261);
      end
      check("c_sig", c_sig, sig_q.pop_front());
      check("c_vec_count", c_vc, 256);

      // reset in the middle of DRIVE on A
      a_hash = 1'b1;
      @(negedge clk) a_start = 1'b1;
      @(negedge clk) a_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("a_pre_rst_vc", a_vc, 1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_stim", a_stim, 0);
      check("midrst_busy", a_busy, 0);
      check("midrst_vec_count", a_vc, 0);
      begin
         int dn;
         dn = 0;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            if (a_done) dn++;
         end
         check("midrst_no_done", dn, 0);
      end
      run_a(1'b1, 8'h00, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
